// File: rtl/dcache_req_arbiter_pkg.sv
// Shared types for the data-cache request arbiter: payload struct, access-size
// enums and the arbiter FSM state encoding.
package dcache_req_arbiter_pkg;

  localparam int DATA_SIZE     = 32;
  // Widest address the payload struct can carry; narrower buses use the low bits.
  localparam int MAX_ADDR_SIZE = 64;

  typedef enum logic [1:0] {
    SOP_B = 2'd0,
    SOP_H = 2'd1,
    SOP_W = 2'd2
  } t_sop;

  typedef enum logic [2:0] {
    LDOP_B  = 3'd0,
    LDOP_H  = 3'd1,
    LDOP_W  = 3'd2,
    LDOP_BU = 3'd3,
    LDOP_HU = 3'd4
  } t_ldop;

  typedef struct packed {
    logic                     write;
    logic [MAX_ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0]     store_data;
    t_sop                     sop;
    t_ldop                    ldop;
  } t_dcache_req;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } t_dcarb_state;

endpackage

// File: rtl/dcache_req_arbiter_if.sv
// Requester-side and cache-side signals of the arbiter; slave is the arbiter's
// view, master is the surrounding requesters plus cache.
interface dcache_req_arbiter_if
  import dcache_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32
);

  logic [NUM_REQ-1:0]                 i_req;
  logic [NUM_REQ-1:0]                 i_req_write;
  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]  i_addr;
  logic [NUM_REQ-1:0][DATA_SIZE-1:0]  i_store_data;
  t_sop  [NUM_REQ-1:0]                i_sop;
  t_ldop [NUM_REQ-1:0]                i_ldop;
  logic [NUM_REQ-1:0]                 i_lock;
  logic [NUM_REQ-1:0]                 o_req_ready;
  logic [NUM_REQ-1:0]                 o_data_valid;
  logic [DATA_SIZE-1:0]               o_data;

  logic                               o_cache_req;
  logic                               o_cache_req_write;
  logic [ADDR_SIZE-1:0]               o_cache_addr;
  logic [DATA_SIZE-1:0]               o_cache_store_data;
  t_sop                               o_cache_sop;
  t_ldop                              o_cache_ldop;
  logic                               i_cache_req_ready;
  logic                               i_cache_data_valid;
  logic [DATA_SIZE-1:0]               i_cache_data;

  modport slave (
    input  i_req, i_req_write, i_addr, i_store_data, i_sop, i_ldop, i_lock,
    output o_req_ready, o_data_valid, o_data,
    output o_cache_req, o_cache_req_write, o_cache_addr, o_cache_store_data,
    output o_cache_sop, o_cache_ldop,
    input  i_cache_req_ready, i_cache_data_valid, i_cache_data
  );

  modport master (
    output i_req, i_req_write, i_addr, i_store_data, i_sop, i_ldop, i_lock,
    input  o_req_ready, o_data_valid, o_data,
    input  o_cache_req, o_cache_req_write, o_cache_addr, o_cache_store_data,
    input  o_cache_sop, o_cache_ldop,
    output i_cache_req_ready, i_cache_data_valid, i_cache_data
  );

endinterface

// File: rtl/dcache_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr, with
// wrap-around; returns a one-hot grant and the winner's index.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]     rot_req;
  logic [IDX_W-1:0] pos [N];
  logic [IDX_W-1:0] off_sel;
  logic             found;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum     = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign pos[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : IDX_W'(sum);
      assign rot_req[gi] = req[pos[gi]];
    end
  endgenerate

  // Lowest rotated offset wins, i.e. the requester closest above ptr.
  always_comb begin
    off_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot_req[i]) begin
        found   = 1'b1;
        off_sel = IDX_W'(i);
      end
    end
  end

  assign idx = pos[off_sel];

  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = found && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/dcache_req_arbiter.sv
// Round-robin sharing of one data-cache port among NUM_REQ requesters.
// Optional owner lock across consecutive requests: define DCACHE_ARB_LOCK_EN.
module dcache_req_arbiter
  import dcache_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32
) (
  input  logic                  i_aclk,
  input  logic                  i_areset_n,
  dcache_req_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  t_dcarb_state       state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  t_dcache_req        payload_reg, payload_next;
  logic [NUM_REQ-1:0] elig_req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               complete;
  logic [IDX_W-1:0]   owner_plus1;
  logic               unused_addr_hi;

  assign owner_plus1    = (owner_reg == IDX_W'(NUM_REQ-1)) ? '0 : owner_reg + IDX_W'(1);
  assign unused_addr_hi = ^payload_reg.addr;

`ifdef DCACHE_ARB_LOCK_EN
  logic lock_valid_reg, lock_valid_next;

  // A held lock narrows eligibility to the owner, even while it is not requesting.
  assign elig_req = lock_valid_reg ? (bus.i_req & (NUM_REQ'(1) << owner_reg)) : bus.i_req;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) lock_valid_reg <= 1'b0;
    else             lock_valid_reg <= lock_valid_next;
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.i_lock;
  assign elig_req    = bus.i_req;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (elig_req),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (grant_idx)
  );

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    owner_next       = owner_reg;
    payload_next     = payload_reg;
    complete         = 1'b0;
    bus.o_req_ready  = '0;
    bus.o_data_valid = '0;
    bus.o_data       = '0;
    bus.o_cache_req  = 1'b0;
`ifdef DCACHE_ARB_LOCK_EN
    lock_valid_next  = lock_valid_reg;
`endif

    case (state_reg)
      IDLE: begin
        // Gate the combinational grant so nothing is accepted while reset is held.
        if (i_areset_n && (|grant)) begin
          bus.o_req_ready               = grant;
          owner_next                    = grant_idx;
          payload_next.write            = bus.i_req_write[grant_idx];
          payload_next.addr             = '0;
          payload_next.addr[ADDR_SIZE-1:0] = bus.i_addr[grant_idx];
          payload_next.store_data       = bus.i_store_data[grant_idx];
          payload_next.sop              = bus.i_sop[grant_idx];
          payload_next.ldop             = bus.i_ldop[grant_idx];
          state_next                    = ISSUE;
        end
      end
      ISSUE: begin
        bus.o_cache_req = 1'b1;
        if (bus.i_cache_req_ready) begin
          state_next = WAIT;
          complete   = bus.i_cache_data_valid;
        end
      end
      WAIT: begin
        complete = bus.i_cache_data_valid;
      end
      default: state_next = IDLE;
    endcase

    if (complete) begin
      bus.o_data_valid[owner_reg] = 1'b1;
      bus.o_data                  = bus.i_cache_data;
      state_next                  = IDLE;
`ifdef DCACHE_ARB_LOCK_EN
      if (bus.i_lock[owner_reg]) begin
        lock_valid_next = 1'b1;
      end else begin
        lock_valid_next = 1'b0;
        rr_ptr_next     = owner_plus1;
      end
`else
      rr_ptr_next = owner_plus1;
`endif
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      owner_reg   <= '0;
      payload_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      owner_reg   <= owner_next;
      payload_reg <= payload_next;
    end
  end

  assign bus.o_cache_req_write  = payload_reg.write;
  assign bus.o_cache_addr       = payload_reg.addr[ADDR_SIZE-1:0];
  assign bus.o_cache_store_data = payload_reg.store_data;
  assign bus.o_cache_sop        = payload_reg.sop;
  assign bus.o_cache_ldop       = payload_reg.ldop;

`ifndef SYNTHESIS
  // A completion with no transaction in flight is dropped; flag it in simulation.
  a_stray_completion: assert property (@(posedge i_aclk) disable iff (!i_areset_n)
    bus.i_cache_data_valid |-> (state_reg != IDLE));
`endif

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed bench for dcache_req_arbiter with four requesters; lock expectations
// follow DCACHE_ARB_LOCK_EN.
module tb_dcache_req_arbiter;
  import dcache_req_arbiter_pkg::*;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  logic t1_active  = 1'b0;
  logic t1_dv1_seen = 1'b0;

  dcache_req_arbiter_if #(.NUM_REQ(N), .ADDR_SIZE(32)) bus ();

  dcache_req_arbiter #(.NUM_REQ(N), .ADDR_SIZE(32)) dut (
    .i_aclk     (clk),
    .i_areset_n (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (t1_active && bus.o_data_valid[1]) t1_dv1_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction from the IDLE cycle, expecting requester exp to win.
  task automatic run_txn(input int exp, input bit same, input logic [N-1:0] lock);
    logic [31:0] d;
    d = 32'hA000_0000 + 32'(exp);
    #1 chk("grant", 64'(bus.o_req_ready), 64'(1) << exp);
    tick();
    bus.i_cache_req_ready = 1'b1;
    bus.i_lock            = lock;
    if (same) begin
      bus.i_cache_data_valid = 1'b1;
      bus.i_cache_data       = d;
    end
    #1;
    chk("issue_req",  64'(bus.o_cache_req), 64'(1));
    chk("issue_addr", 64'(bus.o_cache_addr), 64'(32'h1000 + 32'(16 * exp)));
    chk("issue_rdy",  64'(bus.o_req_ready), 64'(0));
    if (same) begin
      chk("cpl_dv",   64'(bus.o_data_valid), 64'(1) << exp);
      chk("cpl_data", 64'(bus.o_data), 64'(d));
    end
    tick();
    bus.i_cache_req_ready = 1'b0;
    if (!same) begin
      bus.i_cache_data_valid = 1'b1;
      bus.i_cache_data       = d;
      #1;
      chk("cpl_dv",   64'(bus.o_data_valid), 64'(1) << exp);
      chk("cpl_data", 64'(bus.o_data), 64'(d));
      tick();
    end
    bus.i_cache_data_valid = 1'b0;
    bus.i_cache_data       = '0;
    bus.i_lock             = '0;
  endtask

  int               rr_order [5] = '{0, 1, 2, 3, 0};
  int               lk_order [4];
  logic [N-1:0]     lk_bits  [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};

  initial begin
`ifdef DCACHE_ARB_LOCK_EN
    lk_order = '{1, 1, 1, 0};
`else
    lk_order = '{1, 0, 1, 0};
`endif
    bus.i_req = '0;  bus.i_req_write = '0;  bus.i_lock = '0;
    bus.i_addr = '0; bus.i_store_data = '0;
    for (int k = 0; k < N; k++) begin
      bus.i_sop[k]  = SOP_B;
      bus.i_ldop[k] = LDOP_B;
    end
    bus.i_cache_req_ready = 1'b0; bus.i_cache_data_valid = 1'b0; bus.i_cache_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_ready",  64'(bus.o_req_ready), 64'(0));
    chk("rst_dv",     64'(bus.o_data_valid), 64'(0));
    chk("rst_creq",   64'(bus.o_cache_req), 64'(0));
    chk("rst_caddr",  64'(bus.o_cache_addr), 64'(0));
    chk("rst_data",   64'(bus.o_data), 64'(0));
    rst_n = 1'b1;

    // Single load from requester 0, cache answers 3 cycles after the handshake.
    t1_active = 1'b1;
    bus.i_req[0] = 1'b1; bus.i_addr[0] = 32'h100; bus.i_ldop[0] = LDOP_W;
    #1 chk("t1_accept", 64'(bus.o_req_ready), 64'(4'b0001));
    tick();
    bus.i_req[0] = 1'b0; bus.i_cache_req_ready = 1'b1;
    #1;
    chk("t1_creq",  64'(bus.o_cache_req), 64'(1));
    chk("t1_addr1", 64'(bus.o_cache_addr), 64'(32'h100));
    chk("t1_write", 64'(bus.o_cache_req_write), 64'(0));
    chk("t1_ldop",  64'(bus.o_cache_ldop), 64'(LDOP_W));
    tick();
    bus.i_cache_req_ready = 1'b0;
    #1;
    chk("t1_addr2", 64'(bus.o_cache_addr), 64'(32'h100));
    chk("t1_creq0", 64'(bus.o_cache_req), 64'(0));
    chk("t1_dv_c2", 64'(bus.o_data_valid), 64'(0));
    tick();
    #1 chk("t1_dv_c3", 64'(bus.o_data_valid), 64'(0));
    tick();
    bus.i_cache_data_valid = 1'b1; bus.i_cache_data = 32'hDEADBEEF;
    #1;
    chk("t1_dv",   64'(bus.o_data_valid), 64'(4'b0001));
    chk("t1_data", 64'(bus.o_data), 64'(32'hDEADBEEF));
    tick();
    bus.i_cache_data_valid = 1'b0; bus.i_cache_data = '0;
    #1 chk("t1_dv_off", 64'(bus.o_data_valid), 64'(0));
    t1_active = 1'b0;
    chk("t1_dv1_never", 64'(t1_dv1_seen), 64'(0));

    // Round-robin with all four requesting from a freshly reset pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) bus.i_addr[k] = 32'h1000 + 32'(16 * k);
    bus.i_req = 4'b1111;
    for (int t = 0; t < 5; t++) run_txn(rr_order[t], 1'b0, '0);

    // Backpressure: requester 2 store, cache stalls 5 cycles.
    bus.i_req = 4'b0100;
    bus.i_req_write[2] = 1'b1; bus.i_store_data[2] = 32'hCAFE0002; bus.i_sop[2] = SOP_W;
    #1 chk("bp_accept", 64'(bus.o_req_ready), 64'(4'b0100));
    tick();
    bus.i_req = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_creq",  64'(bus.o_cache_req), 64'(1));
      chk("bp_addr",  64'(bus.o_cache_addr), 64'(32'h1020));
      chk("bp_sdata", 64'(bus.o_cache_store_data), 64'(32'hCAFE0002));
      chk("bp_sop",   64'(bus.o_cache_sop), 64'(SOP_W));
      chk("bp_ready", 64'(bus.o_req_ready), 64'(0));
      tick();
    end
    bus.i_cache_req_ready = 1'b1;
    #1 chk("bp_creq_last", 64'(bus.o_cache_req), 64'(1));
    tick();
    bus.i_cache_req_ready = 1'b0; bus.i_cache_data_valid = 1'b1; bus.i_cache_data = '0;
    #1 chk("bp_dv", 64'(bus.o_data_valid), 64'(4'b0100));
    tick();
    bus.i_cache_data_valid = 1'b0;

    // Same-cycle handshake and completion; pointer sits at 3, so 0 wins.
    run_txn(0, 1'b1, '0);
    #1;
    chk("sc_dv_off", 64'(bus.o_data_valid), 64'(0));
    chk("sc_idle",   64'(bus.o_req_ready), 64'(4'b0010));

    // Reset while requester 1 waits for its completion.
    tick();
    bus.i_cache_req_ready = 1'b1;
    #1 chk("rw_creq", 64'(bus.o_cache_req), 64'(1));
    tick();
    bus.i_cache_req_ready = 1'b0;
    #1 chk("rw_wait", 64'(bus.o_cache_req), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("rw_ready", 64'(bus.o_req_ready), 64'(0));
    chk("rw_dv",    64'(bus.o_data_valid), 64'(0));
    chk("rw_caddr", 64'(bus.o_cache_addr), 64'(0));
    chk("rw_cwr",   64'(bus.o_cache_req_write), 64'(0));
    tick();
    chk("rw_dv2",   64'(bus.o_data_valid), 64'(0));
    rst_n = 1'b1;
    #1 chk("rw_first", 64'(bus.o_req_ready), 64'(4'b0001));
    run_txn(0, 1'b1, '0);

    // Requester 1 stores under lock while requester 0 keeps requesting.
    bus.i_req_write[1] = 1'b1;
    for (int t = 0; t < 4; t++) run_txn(lk_order[t], 1'b0, lk_bits[t]);
    bus.i_req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_req_arbiter.md
# dcache_req_arbiter

Shares one data cache request port between NUM_REQ memory-access requesters, e.g. per-hart memory stages or an MMU walker. Arbitration is round-robin. The winning request's payload is registered and issued to the cache, and the block keeps ownership until the cache reports completion. The completion is routed back to the owner only. The block sits between the requesters' memory stages and `data_cache`. It uses the same req/ready/data_valid protocol on both sides.

## Interface
- NUM_REQ, 2: number of requesters, 2..8
- ADDR_SIZE, 32: address width
- i_aclk  in  1  system clock
- i_areset_n  in  1  reset; one clock, reset asynchronous active-low (already decided)
- i_req  in  NUM_REQ  per-requester request
- i_req_write  in  NUM_REQ  1 = store, 0 = load
- i_addr  in  NUM_REQ x ADDR_SIZE  request address
- i_store_data  in  NUM_REQ x DATA_SIZE  store data
- i_sop  in  NUM_REQ x t_sop  store size
- i_ldop  in  NUM_REQ x t_ldop  load size/sign
- i_lock  in  NUM_REQ  hold ownership across consecutive requests (see Configuration)
- o_req_ready  out  NUM_REQ  one-hot accept strobe
- o_data_valid  out  NUM_REQ  one-hot completion to the owner
- o_data  out  DATA_SIZE  load data, broadcast to all requesters
- o_cache_req  out  1  request to the cache
- o_cache_req_write, o_cache_addr, o_cache_store_data, o_cache_sop, o_cache_ldop  out  registered payload
- i_cache_req_ready  in  1  cache accepts o_cache_req
- i_cache_data_valid  in  1  cache completion, asserted for loads and stores
- i_cache_data  in  DATA_SIZE  cache load data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner = first asserted i_req[k] searching from rr_ptr upward, with wrap-around.
  - o_req_ready[winner] = 1, combinationally.
  - On that cycle: capture the payload and owner index, then go to ISSUE.
  - No requests: stay in IDLE.
- ISSUE:
  - o_cache_req = 1 with the captured payload, held stable until i_cache_req_ready.
  - On the handshake: go to WAIT.
  - If i_cache_data_valid is in the same cycle as the handshake: complete immediately, same as in WAIT.
- WAIT:
  - On i_cache_data_valid: o_data_valid[owner] = 1 and o_data = i_cache_data, combinationally.
  - Then rr_ptr = (owner+1) mod NUM_REQ, and the FSM goes to IDLE.
- Requesters are never granted outside IDLE; all o_req_ready are 0 in ISSUE and WAIT.
- i_cache_data_valid outside ISSUE/WAIT is ignored; a simulation assertion flags it.
- A requester must hold i_req and its payload until it sees o_req_ready. Dropping i_req before the grant is allowed; the request is then not served.
- At most one outstanding cache transaction.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0, payload registers = 0.
  - All of o_req_ready, o_data_valid, o_cache_req, o_cache_* = 0; o_data = 0.
- Reset mid-transaction: the transaction is abandoned with no completion pulse. The cache shares i_areset_n.
- Latency with an always-ready cache:
  - Accept at cycle 0.
  - o_cache_req at cycle 1.
  - o_data_valid at cycle 1 + cache latency.
  - Next accept 1 cycle after completion.
- Fairness: with all NUM_REQ requesting continuously, each is served once per NUM_REQ transactions.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Configuration
- DCACHE_ARB_LOCK_EN defined:
  - On completion with i_lock[owner] = 1: lock_valid = 1, and rr_ptr is left unchanged.
  - While lock_valid is set, IDLE grants only the owner. Other requesters wait even when the owner is idle.
  - A completion with i_lock[owner] = 0 clears lock_valid and advances rr_ptr.
  - lock_valid resets to 0.
- DCACHE_ARB_LOCK_EN undefined: the i_lock port exists but is ignored, and no lock register is built.

## Structure
- multicore_pkg additions:
  - t_dcache_req packed struct {write, addr, store_data, sop, ldop}.
  - t_dcarb_state enum.
- Uses DATA_SIZE, t_sop, t_ldop from multicore_pkg.
- Sub-module rr_arbiter: combinational, parameter N; inputs req and ptr; outputs one-hot grant and its index.

## Test plan
- Single request: req0 loads addr 0x100 while the cache returns 0xDEADBEEF after 3 cycles.
  - o_req_ready[0] at cycle 0 and o_cache_addr = 0x100 from cycle 1.
  - o_data_valid = 2'b01 with o_data = 0xDEADBEEF; o_data_valid[1] is never set.
- Round-robin, NUM_REQ = 4, all four requesting continuously: grant order 0, 1, 2, 3, 0, with no requester granted twice in a row.
- Backpressure: i_cache_req_ready low for 5 cycles, then high.
  - o_cache_req and the payload stay constant for all 5 cycles.
  - o_req_ready stays 0 for all requesters throughout.
- Same-cycle completion: i_cache_req_ready and i_cache_data_valid both high in ISSUE.
  - A single o_data_valid pulse, then IDLE on the next cycle.
- Reset asserted in WAIT:
  - All outputs 0 immediately, with no o_data_valid pulse.
  - After release, the first grant goes to requester 0.
- With DCACHE_ARB_LOCK_EN: req1 holds i_lock for 3 stores while req0 requests throughout.
  - Grant order 1, 1, 1, then 0.
  - Without the macro, the order is 1, 0, 1, 0.
